seg_display_scheduler: RTL



---
 rtl/seg_display_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg_display_scheduler.sv
// Time-shares a 4-digit display between three round-robin sources and a pre-empting alarm.
// Optional macro ALARM_BLINK_EN: blink digit_en during alarm with period 2*BLINK_HALF cycles.
module seg_display_scheduler #(
    parameter int HOLD_TICKS = 1000
`ifdef ALARM_BLINK_EN
    ,
    parameter int BLINK_HALF = 125
`endif
) (
    input  logic        clk500hz,
    input  logic        rstn,
    input  logic [2:0]  src_req,
    input  logic [47:0] src_data,
    output logic [2:0]  src_ack,
    input  logic        alarm_req,
    input  logic [15:0] alarm_data,
    output logic [15:0] bcd_num,
    output logic [3:0]  digit_en,
    output logic [1:0]  cur_src
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic [HW-1:0] r_hold_cnt, w_hold_nxt;
    logic [15:0]   r_bcd, w_bcd_nxt;
    logic [3:0]    r_en, w_en_nxt;
    logic [2:0]    r_ack, w_ack_nxt;
    logic [1:0]    r_cur, w_cur_nxt;

    logic          w_any;
    logic [1:0]    w_sel;
    logic [15:0]   w_sel_data;
    logic [15:0]   w_cur_data;

`ifdef ALARM_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF);
    logic [BW-1:0] r_blink_cnt, w_blink_nxt;
`endif

    // Round-robin scan: candidates ptr, ptr+1, ptr+2 (mod 3); the earliest requester wins.
    always_comb begin
        int idx;
        w_any = |src_req;
        w_sel = r_ptr;
        for (int k = 2; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= 3) idx = idx - 3;
            if (src_req[idx]) w_sel = 2'(idx);
        end
    end

    assign w_sel_data = src_data[{w_sel, 4'b0000} +: 16];
    assign w_cur_data = src_data[{r_cur, 4'b0000} +: 16];

    always_ff @(posedge clk500hz or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'd0;
            r_hold_cnt <= '0;
            r_bcd      <= 16'h0000;
            r_en       <= 4'b0000;
            r_ack      <= 3'b000;
            r_cur      <= 2'd0;
`ifdef ALARM_BLINK_EN
            r_blink_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_bcd      <= w_bcd_nxt;
            r_en       <= w_en_nxt;
            r_ack      <= w_ack_nxt;
            r_cur      <= w_cur_nxt;
`ifdef ALARM_BLINK_EN
            r_blink_cnt <= w_blink_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_bcd_nxt   = r_bcd;
        w_en_nxt    = r_en;
        w_ack_nxt   = 3'b000;
        w_cur_nxt   = r_cur;
`ifdef ALARM_BLINK_EN
        w_blink_nxt = '0;
`endif
        if (alarm_req) begin
            w_state_nxt = ST_ALARM;
            w_cur_nxt   = 2'd3;
            w_bcd_nxt   = alarm_data;
            w_hold_nxt  = '0;
`ifdef ALARM_BLINK_EN
            // Counter holds cycles spent in the current blink phase; entry starts a lit phase.
            if (r_state != ST_ALARM) begin
                w_en_nxt    = 4'hF;
                w_blink_nxt = BW'(1);
            end else if (r_blink_cnt == BLINK_LAST) begin
                w_en_nxt    = ~r_en;
                w_blink_nxt = BW'(1);
            end else begin
                w_blink_nxt = r_blink_cnt + BW'(1);
            end
`else
            w_en_nxt = 4'hF;
`endif
        end else if (r_state == ST_SHOW && r_hold_cnt != '0) begin
            w_hold_nxt = r_hold_cnt - HW'(1);
            if (src_req[r_cur]) w_bcd_nxt = w_cur_data;
        end else if (w_any) begin
            // ptr already points past the current source, so it is scanned last.
            w_state_nxt    = ST_SHOW;
            w_bcd_nxt      = w_sel_data;
            w_ack_nxt[w_sel] = 1'b1;
            w_cur_nxt      = w_sel;
            w_en_nxt       = 4'hF;
            w_hold_nxt     = HOLD_LAST;
            w_ptr_nxt      = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
        end else begin
            w_state_nxt = ST_IDLE;
            w_en_nxt    = 4'b0000;
        end
    end

    assign src_ack  = r_ack;
    assign bcd_num  = r_bcd;
    assign digit_en = r_en;
    assign cur_src  = r_cur;

endmodule
